key_device: RTL and testbench

//  Memory-mapped pushbutton input peripheral; the CPU-read counterpart of the hex display output device.

---
 rtl/key_device.sv | 123 ++++++++++++
 tb/tb_key_device.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/key_device.sv
// key_device: memory-mapped pushbutton input peripheral.
//
// Synchronises and (optionally) debounces the raw active-low KEY pins,
// presents the accepted key state as KDATA and flags every change in a
// sticky KCTRL.ready bit that can raise an interrupt.
//
// Register map (full address decode):
//   BASE              KDATA  read {0.., kdata}; writes ignored
//   BASE+CTRL_OFFSET  KCTRL  bit0 ready (RO), bit2 overrun (W0C), bit8 ie (RW)
//
// Ports:
//   clk         system clock, all state on rising edge
//   reset       asynchronous active-low reset
//   we          1 = bus write, 0 = bus read
//   memAddr     bus address
//   dataBusIn   write data
//   dataBusOut  read data, zero when writing or not selected
//   KEY         raw board keys, active-low (0 = pressed)
//   irq         interrupt request = ready & ie
//
// Build option: define KEY_DEBOUNCE_EN to include the per-key debounce
// counters; otherwise the synchronised keys are accepted directly.
module key_device #(
    parameter int              BITS            = 32,
    parameter int              KEY_WIDTH       = 4,
    parameter logic [BITS-1:0] BASE            = 32'hF0000010,
    parameter int              CTRL_OFFSET     = 4,
    parameter int              DEBOUNCE_CYCLES = 500000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [BITS-1:0]      memAddr,
    input  logic [BITS-1:0]      dataBusIn,
    output logic [BITS-1:0]      dataBusOut,
    input  logic [KEY_WIDTH-1:0] KEY,
    output logic                 irq
);
    localparam logic [BITS-1:0] CTRL_ADDR = BASE + BITS'(CTRL_OFFSET);

    logic [KEY_WIDTH-1:0] syncA, syncB, synced, accepted, kdataPrev;
    logic                 ready, overrun, ie;
    logic                 kdataRead, ctrlWrite, change;
    logic                 unusedBits;

    assign unusedBits = ^{dataBusIn[BITS-1:9], dataBusIn[7:3], dataBusIn[1:0]};

    // Two-flop synchroniser; resets to "released" so nothing looks pressed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            syncA <= '1;
            syncB <= '1;
        end else begin
            syncA <= KEY;
            syncB <= syncA;
        end
    end

    assign synced = ~syncB;

`ifdef KEY_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CW-1:0] cnt [KEY_WIDTH];

    // A key flips only after it has differed from the accepted value for
    // DEBOUNCE_CYCLES consecutive clocks; any return to agreement restarts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            accepted <= '0;
            for (int i = 0; i < KEY_WIDTH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < KEY_WIDTH; i++) begin
                if (synced[i] == accepted[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    accepted[i] <= synced[i];
                    cnt[i]      <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end
`else
    assign accepted = synced;
`endif

    assign kdataRead = !we && (memAddr == BASE);
    assign ctrlWrite = we && (memAddr == CTRL_ADDR);
    assign change    = accepted != kdataPrev;

    // A change event always wins over a same-cycle KDATA read, and an
    // overrun being raised wins over a same-cycle KCTRL clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kdataPrev <= '0;
            ready     <= 1'b0;
            overrun   <= 1'b0;
            ie        <= 1'b0;
        end else begin
            kdataPrev <= accepted;
            ready     <= change | (ready & ~kdataRead);
            overrun   <= (change & ready & ~kdataRead) |
                         (overrun & ~(ctrlWrite & ~dataBusIn[2]));
            ie        <= ctrlWrite ? dataBusIn[8] : ie;
        end
    end

    always_comb begin
        dataBusOut = '0;
        if (kdataRead) begin
            dataBusOut[KEY_WIDTH-1:0] = accepted;
        end else if (!we && memAddr == CTRL_ADDR) begin
            dataBusOut[0] = ready;
            dataBusOut[2] = overrun;
            dataBusOut[8] = ie;
        end
    end

    assign irq = ready & ie;

endmodule

// File: tb/tb_key_device.sv
// tb_key_device: directed self-checking bench for key_device.
module tb_key_device;
    localparam logic [31:0] BASE = 32'hF0000010;
    localparam logic [31:0] CTRL = 32'hF0000014;
`ifdef KEY_DEBOUNCE_EN
    localparam int KLAT = 6;
`else
    localparam int KLAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [31:0] memAddr;
    logic [31:0] dataBusIn;
    logic [31:0] dataBusOut;
    logic [3:0]  KEY;
    logic        irq;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expOut;
        logic        expIrq;
    } vec_t;

    vec_t vecs [16];

    key_device #(
        .BITS(32), .KEY_WIDTH(4), .BASE(BASE), .CTRL_OFFSET(4), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset), .we(we), .memAddr(memAddr),
        .dataBusIn(dataBusIn), .dataBusOut(dataBusOut), .KEY(KEY), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic rd(input logic [31:0] a, input string nm, input logic [31:0] exp);
        we = 1'b0;
        memAddr = a;
        #1;
        chk(nm, dataBusOut, exp);
        step(1);
        memAddr = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1;
        memAddr = a;
        dataBusIn = d;
        step(1);
        we = 1'b0;
        memAddr = '0;
        dataBusIn = '0;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 32'hF000000C, 32'h0,        32'h0,   1'b0};
        vecs[1]  = '{1'b0, 32'hF0000018, 32'h0,        32'h0,   1'b0};
        vecs[2]  = '{1'b0, 32'hF0000011, 32'h0,        32'h0,   1'b0};
        vecs[3]  = '{1'b0, CTRL,         32'h0,        32'h1,   1'b0};
        vecs[4]  = '{1'b1, BASE,         32'hFFFF,     32'h0,   1'b0};
        vecs[5]  = '{1'b1, CTRL,         32'h100,      32'h0,   1'b0};
        vecs[6]  = '{1'b0, CTRL,         32'h0,        32'h101, 1'b1};
        vecs[7]  = '{1'b0, 32'h00000010, 32'h0,        32'h0,   1'b1};
        vecs[8]  = '{1'b0, BASE,         32'h0,        32'h1,   1'b1};
        vecs[9]  = '{1'b0, CTRL,         32'h0,        32'h100, 1'b0};
        vecs[10] = '{1'b1, CTRL,         32'hFFFFFEFF, 32'h0,   1'b0};
        vecs[11] = '{1'b0, CTRL,         32'h0,        32'h0,   1'b0};
        vecs[12] = '{1'b1, CTRL,         32'hFFFFFFFF, 32'h0,   1'b0};
        vecs[13] = '{1'b0, CTRL,         32'h0,        32'h100, 1'b0};
        vecs[14] = '{1'b1, CTRL,         32'h0,        32'h0,   1'b0};
        vecs[15] = '{1'b0, CTRL,         32'h0,        32'h0,   1'b0};

        reset = 1'b0; we = 1'b0; memAddr = '0; dataBusIn = '0; KEY = 4'b0000;
        step(2);
        chk("rst irq", {31'b0, irq}, 32'h0);
        rd(BASE, "rst kdata", 32'h0);
        rd(CTRL, "rst kctrl", 32'h0);
        reset = 1'b1;

        // keys held through reset are accepted after sync + debounce
        step(KLAT - 1);
        rd(BASE, "pre-accept kdata", 32'h0);
        rd(CTRL, "ready lag", 32'h0);
        rd(CTRL, "ready after accept", 32'h1);
        rd(BASE, "held keys kdata", 32'hF);
        rd(CTRL, "ready cleared by read", 32'h0);

        KEY = 4'b1111;
        step(10);
        rd(BASE, "release kdata", 32'h0);
        rd(CTRL, "release kctrl", 32'h0);

`ifdef KEY_DEBOUNCE_EN
        KEY = 4'b1101;
        step(2);
        KEY = 4'b1111;
        step(10);
        rd(CTRL, "glitch kctrl", 32'h0);
        rd(BASE, "glitch kdata", 32'h0);
`endif

        KEY = 4'b1110;
        step(10);
        rd(CTRL, "press kctrl", 32'h1);
        rd(BASE, "press kdata", 32'h1);
        rd(CTRL, "press cleared", 32'h0);

        KEY = 4'b1100;
        step(KLAT + 2);
        KEY = 4'b1000;
        step(KLAT + 2);
        rd(CTRL, "overrun set", 32'h5);
        wr(CTRL, 32'h0);
        rd(CTRL, "overrun cleared", 32'h1);
        rd(BASE, "two changes kdata", 32'h7);
        rd(CTRL, "after read", 32'h0);
        chk("irq ie off", {31'b0, irq}, 32'h0);

        wr(CTRL, 32'h100);
        rd(CTRL, "ie set", 32'h100);
        KEY = 4'b0000;
        step(KLAT);
        chk("irq before ready", {31'b0, irq}, 32'h0);
        step(1);
        chk("irq on ready", {31'b0, irq}, 32'h1);
        rd(BASE, "irq kdata", 32'hF);
        chk("irq after read", {31'b0, irq}, 32'h0);

        KEY = 4'b1111;
        step(KLAT + 1);
        KEY = 4'b1110;
        step(KLAT);
        rd(BASE, "read on change", 32'h1);
        rd(CTRL, "change beats read", 32'h101);
        wr(BASE, 32'hFFFF);
        rd(CTRL, "kdata write ignored ctrl", 32'h101);
        rd(BASE, "kdata write ignored", 32'h1);

        KEY = 4'b1111;
        step(KLAT + 1);
        KEY = 4'b1110;
        step(KLAT);
        wr(CTRL, 32'h100);
        rd(CTRL, "overrun beats clear", 32'h105);
        wr(CTRL, 32'h4);
        rd(CTRL, "write1 keeps overrun", 32'h5);
        chk("irq ie cleared", {31'b0, irq}, 32'h0);
        wr(CTRL, 32'h0);
        rd(CTRL, "overrun w0c", 32'h1);

        for (int i = 0; i < 16; i++) begin
            we = vecs[i].we;
            memAddr = vecs[i].addr;
            dataBusIn = vecs[i].wdata;
            #1;
            chk($sformatf("vec%0d out", i), dataBusOut, vecs[i].expOut);
            chk($sformatf("vec%0d irq", i), {31'b0, irq}, {31'b0, vecs[i].expIrq});
            step(1);
        end
        we = 1'b0; memAddr = '0; dataBusIn = '0;

        wr(CTRL, 32'h100);
        KEY = 4'b1111;
        step(KLAT + 1);
        chk("pre-reset irq", {31'b0, irq}, 32'h1);
        KEY = 4'b1110;
        step(2);
        #2 reset = 1'b0;
        memAddr = CTRL;
        #1;
        chk("async rst kctrl", dataBusOut, 32'h0);
        chk("async rst irq", {31'b0, irq}, 32'h0);
        memAddr = BASE;
        #1;
        chk("async rst kdata", dataBusOut, 32'h0);
        memAddr = '0;
        step(2);
        reset = 1'b1;
        step(KLAT);
        rd(CTRL, "post-reset lag", 32'h0);
        rd(CTRL, "post-reset ready", 32'h1);
        rd(BASE, "post-reset kdata", 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
